vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_pixel_tick.sv | 30 +++
 rtl/vga_sync_gen.sv | 127 ++++++++++++
 tb/tb_vga_sync_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants for vga_sync_gen and pixel_gen.
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY    = 640;
  localparam int VGA_H_FRONT      = 16;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BACK       = 48;
  localparam int VGA_V_DISPLAY    = 480;
  localparam int VGA_V_FRONT      = 10;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BACK       = 33;

  localparam int VGA_H_TOTAL      = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL      = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Both sync pulses are active-low in this mode.
  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  // Width of x/y; must hold H_TOTAL-1 and V_TOTAL-1.
  localparam int VGA_SCREEN_WIDTH = 10;

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate strobe: divides sys_clk by CLK_DIV and emits a registered
// one-cycle p_tick each time the divider wraps (constant 1 when CLK_DIV=1).
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Divider counter 0..CLK_DIV-1; p_tick registered on the wrap
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q  <= '0;
      p_tick <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q  <= '0;
      p_tick <= 1'b1;
    end else begin
      div_q  <= div_q + DIV_W'(1);
      p_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing source: pixel tick, h/v counters, registered decode of
// video_on/hsync/vsync/frame pulses, and a once-per-frame camera row latch.
// Optional build macro VGA_SYNC_DELAY_EN: adds one pixel-tick register stage
// on hsync/vsync so they lag x/y by one pixel.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int H_DISPLAY    = VGA_H_DISPLAY,
  parameter int H_FRONT      = VGA_H_FRONT,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BACK       = VGA_H_BACK,
  parameter int V_DISPLAY    = VGA_V_DISPLAY,
  parameter int V_FRONT      = VGA_V_FRONT,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BACK       = VGA_V_BACK,
  parameter int SCREEN_WIDTH = VGA_SCREEN_WIDTH
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [4:0]              camera_y_in,
  output logic                    p_tick,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  output logic                    video_on,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    frame_start,
  output logic                    vblank_start,
  output logic [4:0]              camera_y
);

  localparam int SW      = SCREEN_WIDTH;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [SW-1:0] H_LAST   = SW'(H_TOTAL - 1);
  localparam logic [SW-1:0] V_LAST   = SW'(V_TOTAL - 1);
  localparam logic [SW-1:0] H_VIS    = SW'(H_DISPLAY);
  localparam logic [SW-1:0] V_VIS    = SW'(V_DISPLAY);
  localparam logic [SW-1:0] HS_START = SW'(H_DISPLAY + H_FRONT);
  localparam logic [SW-1:0] HS_END   = SW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [SW-1:0] VS_START = SW'(V_DISPLAY + V_FRONT);
  localparam logic [SW-1:0] VS_END   = SW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [SW-1:0] h_q, v_q;
  logic [SW-1:0] h_next, v_next;
  logic          video_next, hsync_next, vsync_next;
  logic          frame_next, vblank_next;
  logic          hsync_q, vsync_q;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .p_tick    (p_tick)
  );

  // Next raster position and its decode, so registered outputs line up with x/y
  always_comb begin
    h_next = h_q + SW'(1);
    v_next = v_q;
    if (h_q == H_LAST) begin
      h_next = '0;
      v_next = (v_q == V_LAST) ? '0 : v_q + SW'(1);
    end
    video_next  = (h_next < H_VIS) && (v_next < V_VIS);
    hsync_next  = ((h_next >= HS_START) && (h_next < HS_END)) ? VGA_SYNC_ACTIVE : ~VGA_SYNC_ACTIVE;
    vsync_next  = ((v_next >= VS_START) && (v_next < VS_END)) ? VGA_SYNC_ACTIVE : ~VGA_SYNC_ACTIVE;
    frame_next  = (h_next == '0) && (v_next == '0);
    vblank_next = (h_next == '0) && (v_next == V_VIS);
  end

  // Counters and level decodes advance on pixel ticks; pulses last one sys_clk
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_q          <= H_LAST;
      v_q          <= V_LAST;
      video_on     <= 1'b0;
      hsync_q      <= ~VGA_SYNC_ACTIVE;
      vsync_q      <= ~VGA_SYNC_ACTIVE;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      camera_y     <= '0;
    end else if (p_tick) begin
      h_q          <= h_next;
      v_q          <= v_next;
      video_on     <= video_next;
      hsync_q      <= hsync_next;
      vsync_q      <= vsync_next;
      frame_start  <= frame_next;
      vblank_start <= vblank_next;
      if (frame_next) begin
        camera_y <= camera_y_in;
      end
    end else begin
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end
  end

  assign x = h_q;
  assign y = v_q;

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_d, vsync_d;

  // Extra pixel-tick stage so sync matches a registered rgb stage downstream
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync_d <= ~VGA_SYNC_ACTIVE;
      vsync_d <= ~VGA_SYNC_ACTIVE;
    end else if (p_tick) begin
      hsync_d <= hsync_q;
      vsync_d <= vsync_q;
    end
  end

  assign hsync = hsync_d;
  assign vsync = vsync_d;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a shrunken raster (24x14 total, 16x8 visible)
// so full frames fit in a short run; a second instance runs with CLK_DIV=1.
module tb_vga_sync_gen;

  localparam int DIV = 4;
  localparam int SW  = 10;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [4:0]    camera_y_in = 5'd5;

  logic          p_tick, video_on, hsync, vsync, frame_start, vblank_start;
  logic [SW-1:0] x, y;
  logic [4:0]    camera_y;

  logic          p_tick1, video_on1, hsync1, vsync1, frame_start1, vblank_start1;
  logic [SW-1:0] x1, y1;
  logic [4:0]    camera_y1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  vga_sync_gen #(
    .CLK_DIV(DIV), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SCREEN_WIDTH(SW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .camera_y_in(camera_y_in),
    .p_tick(p_tick), .x(x), .y(y), .video_on(video_on), .hsync(hsync),
    .vsync(vsync), .frame_start(frame_start), .vblank_start(vblank_start),
    .camera_y(camera_y)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SCREEN_WIDTH(SW)
  ) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .camera_y_in(camera_y_in),
    .p_tick(p_tick1), .x(x1), .y(y1), .video_on(video_on1), .hsync(hsync1),
    .vsync(vsync1), .frame_start(frame_start1), .vblank_start(vblank_start1),
    .camera_y(camera_y1)
  );

  typedef struct {
    int         ticks;
    logic [4:0] cam_in;
    int         ex;
    int         ey;
    logic       von;
    logic       hs_nd;
    logic       hs_d;
    logic       vs_nd;
    logic       vs_d;
    logic       fs;
    logic       vb;
    logic [4:0] ecam;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n pixel ticks from a point just after a tick edge.
  task automatic adv(input int n);
    repeat (n * DIV) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int   hs_low;
    int   fall_x, rise_x, tick_miss;
    logic prev_hs;
    logic exp_hs, exp_vs;

    //            ticks cam  x   y von hsN hsD vsN vsD fs vb cam
    tbl[0]  = '{ 14, 5, 15,  0, 1, 1, 1, 1, 1, 0, 0, 5};
    tbl[1]  = '{  1, 5, 16,  0, 0, 1, 1, 1, 1, 0, 0, 5};
    tbl[2]  = '{  2, 5, 18,  0, 0, 0, 1, 1, 1, 0, 0, 5};
    tbl[3]  = '{  1, 5, 19,  0, 0, 0, 0, 1, 1, 0, 0, 5};
    tbl[4]  = '{  1, 5, 20,  0, 0, 0, 0, 1, 1, 0, 0, 5};
    tbl[5]  = '{  1, 5, 21,  0, 0, 1, 0, 1, 1, 0, 0, 5};
    tbl[6]  = '{  1, 5, 22,  0, 0, 1, 1, 1, 1, 0, 0, 5};
    tbl[7]  = '{  1, 5, 23,  0, 0, 1, 1, 1, 1, 0, 0, 5};
    tbl[8]  = '{  1, 5,  0,  1, 1, 1, 1, 1, 1, 0, 0, 5};
    tbl[9]  = '{ 72, 9,  0,  4, 1, 1, 1, 1, 1, 0, 0, 5};
    tbl[10] = '{ 95, 9, 23,  7, 0, 1, 1, 1, 1, 0, 0, 5};
    tbl[11] = '{  1, 9,  0,  8, 0, 1, 1, 1, 1, 0, 1, 5};
    tbl[12] = '{  1, 9,  1,  8, 0, 1, 1, 1, 1, 0, 0, 5};
    tbl[13] = '{ 47, 9,  0, 10, 0, 1, 1, 0, 1, 0, 0, 5};
    tbl[14] = '{  1, 9,  1, 10, 0, 1, 1, 0, 0, 0, 0, 5};
    tbl[15] = '{ 47, 9,  0, 12, 0, 1, 1, 1, 0, 0, 0, 5};
    tbl[16] = '{  1, 9,  1, 12, 0, 1, 1, 1, 1, 0, 0, 5};
    tbl[17] = '{ 47, 9,  0,  0, 1, 1, 1, 1, 1, 1, 0, 9};
    tbl[18] = '{  1, 9,  1,  0, 1, 1, 1, 1, 1, 0, 0, 9};

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_x", int'(x), 23);
    check("rst_y", int'(y), 13);
    check("rst_video_on", int'(video_on), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_p_tick", int'(p_tick), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_vblank_start", int'(vblank_start), 0);
    check("rst_camera_y", int'(camera_y), 0);

    // Release: p_tick after the 4th edge, (0,0) on the 5th
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("p_tick_early", int'(p_tick), 0);
    @(posedge sys_clk); #1;
    check("p_tick_first", int'(p_tick), 1);
    check("x_before_tick", int'(x), 23);
    @(posedge sys_clk); #1;
    check("first_x", int'(x), 0);
    check("first_y", int'(y), 0);
    check("first_video_on", int'(video_on), 1);
    check("first_frame_start", int'(frame_start), 1);
    check("first_camera_y", int'(camera_y), 5);
    check("p_tick_after", int'(p_tick), 0);
    @(posedge sys_clk); #1;
    check("frame_start_one_cycle", int'(frame_start), 0);
    check("x_held", int'(x), 0);
    repeat (DIV - 1) @(posedge sys_clk);
    #1;
    check("second_x", int'(x), 1);

    // Table walk through one line, sync windows, vblank and next frame
    for (int i = 0; i < 19; i++) begin
      camera_y_in = tbl[i].cam_in;
      adv(tbl[i].ticks);
`ifdef VGA_SYNC_DELAY_EN
      exp_hs = tbl[i].hs_d;
      exp_vs = tbl[i].vs_d;
`else
      exp_hs = tbl[i].hs_nd;
      exp_vs = tbl[i].vs_nd;
`endif
      check($sformatf("v%0d_x", i), int'(x), tbl[i].ex);
      check($sformatf("v%0d_y", i), int'(y), tbl[i].ey);
      check($sformatf("v%0d_video_on", i), int'(video_on), int'(tbl[i].von));
      check($sformatf("v%0d_hsync", i), int'(hsync), int'(exp_hs));
      check($sformatf("v%0d_vsync", i), int'(vsync), int'(exp_vs));
      check($sformatf("v%0d_frame_start", i), int'(frame_start), int'(tbl[i].fs));
      check($sformatf("v%0d_vblank_start", i), int'(vblank_start), int'(tbl[i].vb));
      check($sformatf("v%0d_camera_y", i), int'(camera_y), int'(tbl[i].ecam));
    end

    // hsync low for exactly H_SYNC ticks over one line
    hs_low = 0;
    for (int i = 0; i < 24; i++) begin
      adv(1);
      if (hsync == 1'b0) hs_low++;
    end
    check("hsync_low_ticks", hs_low, 3);
    check("line_wrap_y", int'(y), 1);

    // Mid-frame asynchronous reset at (10,5)
    adv(105);
    check("pre_rst_x", int'(x), 10);
    check("pre_rst_y", int'(y), 5);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_x", int'(x), 23);
    check("async_rst_y", int'(y), 13);
    check("async_rst_video_on", int'(video_on), 0);
    check("async_rst_hsync", int'(hsync), 1);
    check("async_rst_vsync", int'(vsync), 1);
    check("async_rst_camera_y", int'(camera_y), 0);

    // Release both instances together
    @(negedge sys_clk) sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("div1_p_tick_first", int'(p_tick1), 1);
    check("div1_x_before", int'(x1), 23);
    @(posedge sys_clk); #1;
    check("div1_first_x", int'(x1), 0);
    check("div1_frame_start", int'(frame_start1), 1);
    repeat (2) @(posedge sys_clk);
    #1;
    check("rerst_p_tick", int'(p_tick), 1);
    check("rerst_x_before", int'(x), 23);
    @(posedge sys_clk); #1;
    check("rerst_x", int'(x), 0);
    check("rerst_y", int'(y), 0);
    check("rerst_frame_start", int'(frame_start), 1);
    check("rerst_camera_y", int'(camera_y), 9);

    // CLK_DIV=1: tick every cycle, locate hsync edges by x
    fall_x = -1;
    rise_x = -1;
    tick_miss = 0;
    prev_hs = hsync1;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk); #1;
      if (p_tick1 !== 1'b1) tick_miss++;
      if (prev_hs && !hsync1 && fall_x < 0) fall_x = int'(x1);
      if (!prev_hs && hsync1 && fall_x >= 0 && rise_x < 0) rise_x = int'(x1);
      prev_hs = hsync1;
    end
    check("div1_p_tick_constant", tick_miss, 0);
`ifdef VGA_SYNC_DELAY_EN
    check("div1_hsync_fall_x", fall_x, 19);
    check("div1_hsync_rise_x", rise_x, 22);
`else
    check("div1_hsync_fall_x", fall_x, 18);
    check("div1_hsync_rise_x", rise_x, 21);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
